// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad entry block: debounce state
// encoding, frame result encoding and the physical key map.
package keypad_pkg;

  typedef enum logic [1:0] {
    DEB_IDLE     = 2'd0,
    DEB_DEBOUNCE = 2'd1,
    DEB_HELD     = 2'd2,
    DEB_RELEASE  = 2'd3
  } deb_state_t;

  typedef enum logic [1:0] {
    FRAME_NONE  = 2'd0,
    FRAME_KEY   = 2'd1,
    FRAME_MULTI = 2'd2
  } frame_t;

  // Key code per matrix position, indexed by {row, col}.
  // row0: 1 2 3 A / row1: 4 5 6 B / row2: 7 8 9 C / row3: E(*) 0 F(#) D
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_lookup(input logic [3:0] pos);
    return KEY_MAP[pos];
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Matrix scanner: synchronises the rows, sweeps the columns, classifies
// each full sweep (frame) and debounces presses and releases frame by frame.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_pulse,
  output logic [3:0] key_code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx;
  logic          div_last;
  logic          frame_end;

  logic [3:0]    low_rows;
  logic [2:0]    col_hits;
  logic [1:0]    col_row;
  logic [1:0]    acc_hits;
  logic [3:0]    acc_idx;
  logic [2:0]    hit_sum;
  logic [1:0]    tot_hits;
  logic [3:0]    cur_idx;
  frame_t        frame_res;
  logic [3:0]    frame_key;

  deb_state_t    state;
  deb_state_t    state_nxt;
  logic [3:0]    cand;
  logic [3:0]    cand_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          accept;
  logic          pulse_nxt;
  logic [3:0]    code_nxt;

  assign div_last  = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_end = div_last && (col_idx == 2'd3);
  assign low_rows  = ~row_sync;

  // Two-flop synchroniser for the asynchronous row inputs (idle = pulled up)
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Column dwell counter and rotating active-low column drive
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
      col     <= 4'b1110;
    end else if (div_last) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
      col     <= {col[2:0], col[3]};
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Per-column decode: number of low rows and the lowest low row
  always_comb begin
    col_hits = 3'(low_rows[0]) + 3'(low_rows[1]) + 3'(low_rows[2]) + 3'(low_rows[3]);
    if (low_rows[0])      col_row = 2'd0;
    else if (low_rows[1]) col_row = 2'd1;
    else if (low_rows[2]) col_row = 2'd2;
    else if (low_rows[3]) col_row = 2'd3;
    else                  col_row = 2'd0;
  end

  // Merge this column's sample with the frame so far; hit count saturates at 2
  always_comb begin
    hit_sum   = 3'(acc_hits) + col_hits;
    tot_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    cur_idx   = (acc_hits == 2'd0) ? {col_row, col_idx} : acc_idx;
    frame_key = key_lookup(cur_idx);
    case (tot_hits)
      2'd0:    frame_res = FRAME_NONE;
      2'd1:    frame_res = FRAME_KEY;
      default: frame_res = FRAME_MULTI;
    endcase
  end

  // Frame accumulator: collects samples at the end of each column dwell
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hits <= 2'd0;
      acc_idx  <= 4'd0;
    end else if (frame_end) begin
      acc_hits <= 2'd0;
      acc_idx  <= 4'd0;
    end else if (div_last) begin
      acc_hits <= tot_hits;
      acc_idx  <= cur_idx;
    end else begin
      acc_hits <= acc_hits;
      acc_idx  <= acc_idx;
    end
  end

  // Debounce state register with registered key outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DEB_IDLE;
      cand      <= 4'd0;
      cnt       <= '0;
      key_pulse <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      key_pulse <= pulse_nxt;
      key_code  <= code_nxt;
    end
  end

  // Debounce next state; cnt counts matching press frames, then release frames
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (frame_end) begin
      case (state)
        DEB_IDLE: begin
          if (frame_res == FRAME_KEY) begin
            cand_nxt  = frame_key;
            cnt_nxt   = CW'(1);
            state_nxt = DEB_DEBOUNCE;
          end else begin
            state_nxt = DEB_IDLE;
          end
        end
        DEB_DEBOUNCE: begin
          if (frame_res == FRAME_KEY && frame_key == cand) begin
            if (int'(cnt) + 1 >= DEBOUNCE_CNT) begin
              accept    = 1'b1;
              cnt_nxt   = '0;
              state_nxt = DEB_HELD;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end else if (frame_res == FRAME_KEY) begin
            cand_nxt = frame_key;
            cnt_nxt  = CW'(1);
          end else begin
            cnt_nxt   = '0;
            state_nxt = DEB_IDLE;
          end
        end
        DEB_HELD: begin
          if (frame_res == FRAME_NONE) begin
            cnt_nxt   = CW'(1);
            state_nxt = DEB_RELEASE;
          end else begin
            state_nxt = DEB_HELD;
          end
        end
        DEB_RELEASE: begin
          if (frame_res == FRAME_NONE) begin
            if (int'(cnt) + 1 >= DEBOUNCE_CNT) begin
              cnt_nxt   = '0;
              state_nxt = DEB_IDLE;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = DEB_HELD;
          end
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = DEB_IDLE;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // Output decode: one pulse per accepted press, code held until the next one
  always_comb begin
    pulse_nxt = accept;
    if (accept) code_nxt = cand;
    else        code_nxt = key_code;
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad number entry: accumulates debounced key presses into a hex or
// decimal value, commits it on enter and clears on clr or a radix change.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int NUM_DIGITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        base,
  input  logic        enter,
  input  logic        clr,
  output logic        key_pulse,
  output logic [3:0]  key_code,
  output logic [31:0] entry,
  output logic [3:0]  digit_cnt,
  output logic [31:0] data,
  output logic        data_valid
);

  logic        base_prev;
  logic        base_chg;
  logic        room;
  logic        key_ok;
  logic [31:0] dec_val;
  logic [31:0] hex_val;
  logic [31:0] entry_nxt;
  logic [3:0]  cnt_nxt;
  logic [31:0] data_nxt;
  logic        valid_nxt;

  keypad_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_pulse (key_pulse),
    .key_code  (key_code)
  );

  assign base_chg = base ^ base_prev;
  assign room     = (digit_cnt < 4'(NUM_DIGITS));
  assign key_ok   = base ? (key_code <= 4'd9) : 1'b1;
  assign dec_val  = (entry << 3) + (entry << 1) + {28'd0, key_code};
  assign hex_val  = {entry[27:0], key_code};

  // Event priority: clear/radix change, then commit, then digit entry
  always_comb begin
    entry_nxt = entry;
    cnt_nxt   = digit_cnt;
    data_nxt  = data;
    valid_nxt = 1'b0;
    if (clr || base_chg) begin
      entry_nxt = 32'd0;
      cnt_nxt   = 4'd0;
    end else if (enter) begin
      data_nxt  = entry;
      valid_nxt = 1'b1;
      entry_nxt = 32'd0;
      cnt_nxt   = 4'd0;
    end else if (key_pulse && key_ok && room) begin
      entry_nxt = base ? dec_val : hex_val;
      cnt_nxt   = digit_cnt + 4'd1;
    end else begin
      entry_nxt = entry;
    end
  end

  // Accumulator, commit register and radix edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      base_prev  <= 1'b0;
      entry      <= 32'd0;
      digit_cnt  <= 4'd0;
      data       <= 32'd0;
      data_valid <= 1'b0;
    end else begin
      base_prev  <= base;
      entry      <= entry_nxt;
      digit_cnt  <= cnt_nxt;
      data       <= data_nxt;
      data_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: a physical keypad model drives the
// rows from the pressed-key set, and a frame-level reference model predicts
// key pulses and the accumulated / committed values.
module tb_keypad_entry;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 2;
  localparam int NUM_DIGITS   = 8;
  localparam int FRAME_CYC    = 4 * SCAN_DIV;
  localparam int CTL_ENTER    = 1;
  localparam int CTL_CLR      = 2;
  localparam logic [15:0] ONE16 = 16'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        base = 1'b0;
  logic        enter = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_pulse;
  logic [3:0]  key_code;
  logic [31:0] entry;
  logic [3:0]  digit_cnt;
  logic [31:0] data;
  logic        data_valid;
  logic [15:0] pressed = 16'd0;

  always #5 clk = ~clk;

  keypad_entry #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .NUM_DIGITS   (NUM_DIGITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .base       (base),
    .enter      (enter),
    .clr        (clr),
    .key_pulse  (key_pulse),
    .key_code   (key_code),
    .entry      (entry),
    .digit_cnt  (digit_cnt),
    .data       (data),
    .data_valid (data_valid)
  );

  // Keypad matrix: a row reads low when a pressed key sits on the driven column
  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r*4 +: 4] & ~col);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int seen_pulses = 0;
  int seen_valid  = 0;

  // Count high cycles of the pulse outputs
  always @(negedge clk) begin
    if (key_pulse === 1'b1)  seen_pulses <= seen_pulses + 1;
    if (data_valid === 1'b1) seen_valid  <= seen_valid + 1;
  end

  // Key code of each matrix position, row by row
  logic [3:0] key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

  // Reference model state
  int          run_kind;   // -1 none yet, 0 no key, 1 single key, 2 multiple
  int          run_key;
  int          run_len;
  bit          armed;
  bit          pend;
  logic [3:0]  pend_key;
  logic [31:0] m_entry;
  logic [31:0] m_data;
  int          m_cnt;
  bit          m_base_prev;
  int          exp_pulses = 0;
  int          exp_valid  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    run_kind = -1; run_key = 0; run_len = 0; armed = 1'b1; pend = 1'b0; pend_key = 4'd0;
    m_entry = 32'd0; m_data = 32'd0; m_cnt = 0; m_base_prev = 1'b0;
  endtask

  // One clock of entry behaviour with the given simultaneous events
  task automatic model_cycle(input bit kv, input logic [3:0] k, input bit c, input bit e, input bit b);
    if (c) begin
      m_entry = 32'd0; m_cnt = 0;
    end else if (e) begin
      m_data = m_entry; exp_valid++; m_entry = 32'd0; m_cnt = 0;
    end else if (kv && m_cnt < NUM_DIGITS && !(b && k > 4'd9)) begin
      if (b) m_entry = m_entry * 32'd10 + 32'(k);
      else   m_entry = (m_entry << 4) | 32'(k);
      m_cnt++;
    end
  endtask

  task automatic do_reset(input bit b);
    rst = 1'b1; enter = 1'b0; clr = 1'b0; base = b;
    @(posedge clk); #1;
    check_eq("rst_col", 32'(col), 32'h0000000E);
    check_eq("rst_key_pulse", 32'(key_pulse), 32'd0);
    check_eq("rst_key_code", 32'(key_code), 32'd0);
    check_eq("rst_entry", entry, 32'd0);
    check_eq("rst_digit_cnt", 32'(digit_cnt), 32'd0);
    check_eq("rst_data", data, 32'd0);
    check_eq("rst_data_valid", 32'(data_valid), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // One full scan frame with a fixed pressed set; ctl pulses enter/clr at cycle off
  task automatic run_frame(input logic [15:0] mask, input bit b, input int ctl, input int off);
    int  nkeys;
    int  idx;
    int  kind;
    bit  chg;
    bit  fire;
    bit  c_e;
    bit  e_e;
    pressed = mask;
    base    = b;
    chg = (b != m_base_prev);
    m_base_prev = b;
    c_e = ((ctl & CTL_CLR) != 0);
    e_e = ((ctl & CTL_ENTER) != 0);
    model_cycle(pend, pend_key, chg || (c_e && off == 0), e_e && off == 0, b);
    pend = 1'b0;
    if (off != 0) model_cycle(1'b0, 4'd0, c_e, e_e, b);
    for (int i = 0; i < FRAME_CYC; i++) begin
      if (i == off) begin enter = e_e; clr = c_e; end
      else begin enter = 1'b0; clr = 1'b0; end
      @(posedge clk); #1;
    end
    enter = 1'b0; clr = 1'b0;
    nkeys = 0; idx = 0;
    for (int k = 0; k < 16; k++) if (mask[k]) begin nkeys++; idx = k; end
    kind = (nkeys == 0) ? 0 : ((nkeys == 1) ? 1 : 2);
    if (kind == run_kind && (kind != 1 || idx == run_key)) run_len++;
    else begin run_kind = kind; run_key = idx; run_len = 1; end
    fire = 1'b0;
    if (armed && run_kind == 1 && run_len >= DEBOUNCE_CNT) begin fire = 1'b1; armed = 1'b0; end
    else if (!armed && run_kind == 0 && run_len >= DEBOUNCE_CNT) armed = 1'b1;
    check_eq("key_pulse", 32'(key_pulse), 32'(fire));
    if (fire) check_eq("key_code", 32'(key_code), 32'(key_tab[idx]));
    check_eq("pulse_count", 32'(seen_pulses), 32'(exp_pulses));
    check_eq("valid_count", 32'(seen_valid), 32'(exp_valid));
    check_eq("entry", entry, m_entry);
    check_eq("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
    check_eq("data", data, m_data);
    if (fire) begin exp_pulses++; pend = 1'b1; pend_key = key_tab[idx]; end
  endtask

  task automatic frames(input logic [15:0] mask, input bit b, input int n);
    for (int i = 0; i < n; i++) run_frame(mask, b, 0, 0);
  endtask

  task automatic tap(input int idx, input bit b);
    frames(ONE16 << idx, b, 2);
    frames(16'd0, b, 2);
  endtask

  initial begin
    int p0;
    int v0;
    int r;
    int ctl;
    int off;
    int hold;
    bit b;
    logic [15:0] m;

    do_reset(1'b0);
    frames(16'd0, 1'b0, 1);

    // Hex: '6' then 'A'
    frames(ONE16 << 6, 1'b0, 3);
    frames(16'd0, 1'b0, 3);
    frames(ONE16 << 3, 1'b0, 3);
    frames(16'd0, 1'b0, 3);
    check_eq("hex_6A_entry", entry, 32'h0000006A);
    check_eq("hex_6A_cnt", 32'(digit_cnt), 32'd2);

    // Decimal 1,2,3 then enter
    frames(16'd0, 1'b1, 1);
    tap(0, 1'b1); tap(1, 1'b1); tap(2, 1'b1);
    v0 = seen_valid;
    run_frame(16'd0, 1'b1, CTL_ENTER, 3);
    check_eq("dec_data", data, 32'd123);
    check_eq("dec_valid_once", 32'(seen_valid - v0), 32'd1);
    check_eq("dec_entry_cleared", entry, 32'd0);

    // Bounce on '5', then a long hold with no repeat
    frames(16'd0, 1'b0, 1);
    p0 = seen_pulses;
    for (int i = 0; i < 3; i++) begin
      frames(ONE16 << 5, 1'b0, 1);
      frames(16'd0, 1'b0, 1);
    end
    check_eq("bounce_no_pulse", 32'(seen_pulses - p0), 32'd0);
    frames(ONE16 << 5, 1'b0, 22);
    frames(16'd0, 1'b0, 3);
    check_eq("bounce_one_pulse", 32'(seen_pulses - p0), 32'd1);

    // Saturation: nine '1' presses in hex
    run_frame(16'd0, 1'b0, CTL_CLR, 2);
    for (int i = 0; i < 9; i++) tap(0, 1'b0);
    check_eq("sat_entry", entry, 32'h11111111);
    check_eq("sat_cnt", 32'(digit_cnt), 32'd8);

    // Decimal ignores 'C'
    frames(16'd0, 1'b1, 1);
    tap(8, 1'b1);
    tap(11, 1'b1);
    check_eq("dec_C_ignored", entry, 32'd7);

    // Enter in the same cycle as a key pulse: commit 7, drop the key
    frames(ONE16 << 2, 1'b1, 2);
    run_frame(16'd0, 1'b1, CTL_ENTER, 0);
    check_eq("enter_beats_key_data", data, 32'd7);
    frames(16'd0, 1'b1, 1);
    check_eq("enter_beats_key_entry", entry, 32'd0);

    // Two keys together never produce a pulse
    p0 = seen_pulses;
    frames((ONE16 << 0) | (ONE16 << 1), 1'b1, 5);
    frames(16'd0, 1'b1, 3);
    check_eq("multi_no_pulse", 32'(seen_pulses - p0), 32'd0);

    // clr together with enter: nothing committed
    tap(4, 1'b1);
    v0 = seen_valid;
    run_frame(16'd0, 1'b1, CTL_ENTER | CTL_CLR, 5);
    check_eq("clr_beats_enter", 32'(seen_valid - v0), 32'd0);

    // Reset while a key is held, key still down afterwards
    frames(ONE16 << 9, 1'b1, 3);
    p0 = seen_pulses;
    do_reset(1'b1);
    frames(ONE16 << 9, 1'b1, 3);
    frames(16'd0, 1'b1, 3);
    check_eq("reset_held_one_pulse", 32'(seen_pulses - p0), 32'd1);

    // Randomised key activity, control pulses and radix changes
    m = 16'd0; b = 1'b1; hold = 0;
    for (int f = 0; f < 260; f++) begin
      if (hold == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4)      m = 16'd0;
        else if (r < 9) m = ONE16 << $urandom_range(0, 15);
        else            m = (ONE16 << $urandom_range(0, 15)) | (ONE16 << $urandom_range(0, 15));
        hold = $urandom_range(1, 4);
      end
      hold--;
      r = $urandom_range(0, 19);
      ctl = (r == 0) ? CTL_ENTER : ((r == 1) ? CTL_CLR : ((r == 2) ? (CTL_ENTER | CTL_CLR) : 0));
      off = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 14);
      if ($urandom_range(0, 39) == 0) b = ~b;
      run_frame(m, b, ctl, off);
    end
    frames(16'd0, b, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart of the 8-digit display driver. It scans a 4x4 matrix keypad, debounces key presses, and assembles digits into a 32-bit number in decimal or hex.
- The number is committed to `data` on enter.
- `entry` is the live value, wired to the display driver's `data` input. `base` is shared with the display so input and display radix always match.

Parameters:
- SCAN_DIV, 50000: clk cycles each column is driven.
- DEBOUNCE_CNT, 4: consecutive identical full-scan frames needed to accept a press or a release.
- NUM_DIGITS, 8: maximum digits accepted per entry.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- row  in  4  raw keypad rows, active-low (pulled up), asynchronous to clk.
- col  out  4  column drive, active-low, exactly one bit low at a time.
- base  in  1  1 = decimal, 0 = hex.
- enter  in  1  single-cycle commit pulse, already debounced.
- clr  in  1  single-cycle clear pulse, already debounced.
- key_pulse  out  1  one-cycle pulse per accepted key press.
- key_code  out  4  code of the last accepted key.
- entry  out  32  accumulator holding the value being typed.
- digit_cnt  out  4  number of digits accepted in `entry`.
- data  out  32  last committed value.
- data_valid  out  1  one-cycle pulse when `data` updates.

Behaviour:
- Reset values:
  - col = 4'b1110; all other outputs = 0.
  - Scan FSM = IDLE; all counters = 0.
- Row synchronisation: `row` passes through a 2-flop synchroniser before any use.
- Scanning:
  - Column index c advances 0→1→2→3→0 every SCAN_DIV cycles; col = ~(1<<c).
  - Rows are sampled on the last cycle of each column dwell.
  - One sweep of 4 columns is one frame.
- Frame result (evaluated at the end of the column-3 dwell):
  - NONE: no row is low.
  - KEY(k): exactly one key is low across the whole frame.
  - MULTI: more than one key is low.
- Key map, by row, columns 0..3:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E(*) 0 F(#) D
- Debounce FSM, updated only at frame end:
  - IDLE: KEY(k) → cand = k, cnt = 1, go to DEBOUNCE.
  - DEBOUNCE:
    - KEY(cand) → cnt++. When cnt reaches DEBOUNCE_CNT: key_code = cand, key_pulse for 1 cycle, go to HELD.
    - KEY(other) → cand = other, cnt = 1.
    - NONE or MULTI → go to IDLE.
  - HELD:
    - NONE → rel = 1, go to RELEASE.
    - KEY or MULTI → stay (no auto-repeat).
  - RELEASE:
    - NONE → rel++. When rel reaches DEBOUNCE_CNT, go to IDLE.
    - KEY or MULTI → go to HELD.
- Accumulation on key_pulse (takes effect 1 cycle later):
  - Hex: if digit_cnt < NUM_DIGITS, entry = {entry[27:0], key}, digit_cnt++.
  - Decimal: keys > 9 are ignored. Otherwise, if digit_cnt < NUM_DIGITS, entry = entry*10 + key (32-bit; cannot overflow for 8 digits), digit_cnt++.
  - Once digit_cnt = NUM_DIGITS, further digits are ignored.
  - Leading zeros still count toward digit_cnt.
- Enter: data = entry and data_valid pulses 1 cycle after enter. In the same update, entry = 0 and digit_cnt = 0. Enter with digit_cnt = 0 commits 0 and still pulses.
- clr: entry = 0 and digit_cnt = 0; data is untouched.
- A change of `base` (edge detected) clears entry and digit_cnt, exactly as clr does.
- Simultaneous events, by priority:
  1. clr or base change beats everything: no commit, and any key that cycle is dropped.
  2. enter beats key_pulse: the pre-key entry is committed and the key is dropped.
- `data` holds its value between commits. Reset mid-scan or mid-debounce returns every state to the reset values on the next edge.

Decomposition:
- Shared package keypad_pkg holds:
  - the key-map constant array indexed by {row, col};
  - the debounce state encoding (IDLE, DEBOUNCE, HELD, RELEASE);
  - the frame result encoding (NONE, KEY, MULTI).
- Sub-module keypad_scan contains the synchroniser, the column scan and the debounce FSM, with outputs key_pulse and key_code.
- The top level keypad_entry contains the accumulator, digit counter and commit logic.

Test Plan (SCAN_DIV = 4, DEBOUNCE_CNT = 2):
- Hex entry: hold row1 low during col2 for 3 frames (key '6'), release 3 frames, then press 'A' → single key_pulse each; entry = 0x0000006A, digit_cnt = 2.
- Decimal commit: base = 1, keys 1, 2, 3, then enter → data = 123, data_valid high for exactly 1 cycle; entry = 0, digit_cnt = 0.
- Bounce: key '5' low for 1 frame, high for 1 frame, repeated 3 times, then held → no key_pulse during the bounce; exactly one pulse after 2 stable frames; holding 20 frames gives no repeat.
- Saturation and ignore: hex, press '1' nine times → entry = 0x11111111, digit_cnt = 8. Decimal 'C' → no change to entry.
- Multi-key and simultaneous events:
  - '1' and '2' held together → no key_pulse.
  - enter and key_pulse in the same cycle with entry = 7 → data = 7 and the key is dropped.
  - clr with enter in the same cycle → no data_valid.
- Reset: rst during the HELD state → col = 1110 and all outputs = 0 after 1 edge; the key is still held, so 2 frames later exactly one new key_pulse.
